// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 memory requester driving a single-ported synchronous RAM
//
// Accepts one read/write request at a time over a valid/ready handshake,
// waits WAIT_STATES cycles, issues a single-cycle RAM access, captures read
// data from the RAM's registered output and pulses rsp_valid for one cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (accepted only in IDLE)
//   req_we/req_addr/req_wdata request contents, latched at acceptance
//   rsp_valid                one-cycle completion pulse (LC-3 R signal)
//   rsp_rdata                last read value; only updated by reads
//   ram_en/ram_wr_en/ram_addr/ram_wr_data/ram_rd_data  spram interface
module lc3_mem_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, rsp_q, en_q, wen_q;
  logic                    accept;

  assign accept = (state_q == S_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT != 8'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        // Counter was loaded with WAIT_STATES, so leaving at 1 gives exactly that many WAIT cycles.
        if (cnt_q <= 8'd1) state_d = S_ACCESS;
      end
      S_ACCESS:  state_d = we_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: begin
        rdata_d = ram_rd_data;
        state_d = S_RESP;
      end
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Handshake and RAM strobes are registered from the next state, so each is a
  // pure function of the current registered state with no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      rsp_q   <= 1'b0;
      en_q    <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= (state_d == S_IDLE);
      rsp_q   <= (state_d == S_RESP);
      en_q    <= (state_d == S_ACCESS);
      wen_q   <= (state_d == S_ACCESS) && we_d;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_q;
  assign rsp_rdata   = rdata_q;
  assign ram_en      = en_q;
  assign ram_wr_en   = wen_q;
  assign ram_addr    = addr_q;
  assign ram_wr_data = wdata_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - self-checking bench for lc3_mem_ctrl at WAIT_STATES 0, 2 and 3
module tb_lc3_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid [3];
  logic [15:0] rsp_rdata [3];
  logic        ram_en    [3];
  logic        ram_wr_en [3];
  logic [15:0] ram_addr  [3];
  logic [15:0] ram_wr_data [3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] ref_mem [int];
  logic [15:0] last_rdata [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int idx);
    return (idx == 0) ? 0 : ((idx == 1) ? 2 : 3);
  endfunction

  function automatic logic [15:0] ref_init(input int idx, input int addr);
    if (idx == 2 && addr == 'h42) return 16'h1234;
    return 16'((addr * 7) ^ (idx * 'h1111) ^ 'h5A5A);
  endfunction

  function automatic logic [15:0] ref_read(input int idx, input int addr);
    int key;
    key = idx * 65536 + addr;
    if (ref_mem.exists(key)) return ref_mem[key];
    return ref_init(idx, addr);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] mem [0:65535];
    logic [15:0] rd_q;

    lc3_mem_ctrl #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .ram_en     (ram_en[g]),
      .ram_wr_en  (ram_wr_en[g]),
      .ram_addr   (ram_addr[g]),
      .ram_wr_data(ram_wr_data[g]),
      .ram_rd_data(rd_q)
    );

    initial begin
      rd_q = 16'h0;
      for (int i = 0; i < 65536; i++) mem[i] = ref_init(g, i);
    end

    always @(posedge clk) begin
      if (ram_en[g]) begin
        if (ram_wr_en[g]) mem[ram_addr[g]] <= ram_wr_data[g];
        rd_q <= mem[ram_addr[g]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance idx, starting and ending at a negedge with the DUT idle.
  task automatic txn(input int idx, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    int w, exp_rsp, en_at, rsp_at, en_cnt, rsp_cnt, bad;
    logic [15:0] rd_seen, exp_rd;
    w = ws_of(idx);
    exp_rsp = w + (we ? 2 : 3);
    en_at = -1; rsp_at = -1; en_cnt = 0; rsp_cnt = 0; bad = 0; rd_seen = 16'hxxxx;
    check($sformatf("ready_idle[%0d]", idx), 32'(req_ready[idx]), 32'd1);
    req_valid[idx] = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Scramble request inputs after acceptance; the latched values must not move.
    req_valid[idx] = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    for (int k = 1; k <= exp_rsp + 1; k++) begin
      @(negedge clk);
      if (ram_en[idx] === 1'b1) begin
        en_cnt++;
        if (en_at < 0) en_at = k;
        if (ram_wr_en[idx] !== we) bad++;
      end else if (ram_wr_en[idx] !== 1'b0) bad++;
      if (rsp_valid[idx] === 1'b1) begin
        rsp_cnt++;
        if (rsp_at < 0) begin rsp_at = k; rd_seen = rsp_rdata[idx]; end
      end
      if (k <= exp_rsp && (ram_addr[idx] !== addr || ram_wr_data[idx] !== wdata)) bad++;
      if (req_ready[idx] !== (k > exp_rsp)) bad++;
    end
    exp_rd = we ? last_rdata[idx] : ref_read(idx, 32'(addr));
    check($sformatf("en_cycle[%0d]", idx),  32'(en_at),   32'(w + 1));
    check($sformatf("en_count[%0d]", idx),  32'(en_cnt),  32'd1);
    check($sformatf("rsp_cycle[%0d]", idx), 32'(rsp_at),  32'(exp_rsp));
    check($sformatf("rsp_count[%0d]", idx), 32'(rsp_cnt), 32'd1);
    check($sformatf("busy_sigs[%0d]", idx), 32'(bad),     32'd0);
    check($sformatf("rsp_rdata[%0d] a=%0h", idx, addr), 32'(rd_seen), 32'(exp_rd));
    if (we) ref_mem[idx * 65536 + 32'(addr)] = wdata;
    else    last_rdata[idx] = exp_rd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addr_at [0:31];
    int bad;
    for (int i = 0; i < 3; i++) begin req_valid[i] = 1'b0; last_rdata[i] = 16'h0; end
    req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    rst = 1'b1;

    // Reset held with requests toggling: no activity, idle outputs.
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0 || ram_en[i] !== 1'b0 ||
            ram_wr_en[i] !== 1'b0 || rsp_rdata[i] !== 16'h0 || ram_addr[i] !== 16'h0 ||
            ram_wr_data[i] !== 16'h0) bad++;
        req_valid[i] = c[0];
      end
      req_we = 1'b1; req_addr = 16'($urandom); req_wdata = 16'($urandom);
    end
    check("reset_state", 32'(bad), 32'd0);
    for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // W=0 write then read back.
    txn(0, 1'b1, 16'h3000, 16'hBEEF);
    txn(0, 1'b0, 16'h3000, 16'h0000);

    // W=3 read of preloaded location.
    txn(2, 1'b0, 16'h0042, 16'h0000);

    // Boundary addresses.
    txn(0, 1'b1, 16'hFFFF, 16'hAAAA);
    txn(0, 1'b1, 16'h0000, 16'h5555);
    txn(0, 1'b0, 16'hFFFF, 16'h0000);
    txn(0, 1'b0, 16'h0000, 16'h0000);
    txn(0, 1'b1, 16'h1234, 16'h9999);
    check("rdata_after_write", 32'(rsp_rdata[0]), 32'h5555);

    // Back-to-back reads, W=0: accept every 4th cycle, address changing each cycle.
    req_we = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("b2b_ready c=%0d", c), 32'(req_ready[0]), 32'((c % 4) == 0));
      check($sformatf("b2b_rsp c=%0d", c), 32'(rsp_valid[0]), 32'((c % 4) == 3));
      if ((c % 4) == 3) begin
        check($sformatf("b2b_rdata c=%0d", c), 32'(rsp_rdata[0]), 32'(ref_read(0, 32'(addr_at[c - 3]))));
        last_rdata[0] = ref_read(0, 32'(addr_at[c - 3]));
      end
      addr_at[c] = 16'h3000 + 16'($urandom_range(0, 7));
      req_addr = addr_at[c];
      req_valid[0] = 1'b1;
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);

    // Reset during WAIT on the W=2 instance: write must be abandoned.
    req_valid[1] = 1'b1; req_we = 1'b1; req_addr = 16'h4000; req_wdata = 16'hDEAD;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready_async", 32'(req_ready[1]), 32'd1);
    for (int i = 0; i < 3; i++) last_rdata[i] = 16'h0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ram_en[1] !== 1'b0 || rsp_valid[1] !== 1'b0) bad++;
    end
    check("midrst_no_activity", 32'(bad), 32'd0);
    check("midrst_rdata_cleared", 32'(rsp_rdata[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    txn(1, 1'b0, 16'h4000, 16'h0000);
    check("midrst_not_written", 32'(rsp_rdata[1] === 16'hDEAD), 32'd0);

    // Randomized traffic across all three instances.
    for (int n = 0; n < 30; n++) begin
      txn($urandom_range(0, 2), 1'($urandom), 16'h5000 + 16'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory requester that drives the single-ported synchronous RAM (spram) on behalf of the LC-3 datapath.
- Accepts one read or write request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, issues a single-cycle RAM access, and captures read data from the RAM's registered output.
- Signals completion with a one-cycle response pulse, equivalent to the LC-3 memory-ready (R) signal.

Parameters:
ADDR_WIDTH, 16, address width; matches the spram ADDR_WIDTH.
DATA_WIDTH, 16, data width; matches the spram DATA_WIDTH.
WAIT_STATES, 0, idle cycles inserted between request acceptance and the RAM access (0..255).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  request address.
req_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  one-cycle completion pulse (reads and writes).
rsp_rdata  out  DATA_WIDTH  read data; holds the last read value.
ram_en  out  1  to spram en.
ram_wr_en  out  1  to spram wr_en.
ram_addr  out  ADDR_WIDTH  to spram addr.
ram_wr_data  out  DATA_WIDTH  to spram wr_data.
ram_rd_data  in  DATA_WIDTH  from spram rd_data; valid one cycle after a read access.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - rsp_rdata, latched we/addr/wdata and the wait counter go to 0.
  - Outputs: req_ready=1, rsp_valid=0, ram_en=0, ram_wr_en=0, ram_addr=0, ram_wr_data=0.
- States: IDLE, WAIT, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: latch req_we, req_addr and req_wdata; load counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise ACCESS.
- WAIT:
  - Counter decrements each cycle.
  - When counter==1, next state is ACCESS. WAIT therefore lasts exactly WAIT_STATES cycles.
- ACCESS:
  - ram_en=1 for exactly this one cycle; ram_wr_en = latched we.
  - Next state: write goes to RESP; read goes to CAPTURE.
- CAPTURE (reads only): rsp_rdata <= ram_rd_data at the end of the cycle; next state RESP.
- RESP: rsp_valid=1 for exactly one cycle; next state IDLE.
- Output decode:
  - req_ready, rsp_valid, ram_en and ram_wr_en are decoded from the registered state only, with no combinational path from req_* inputs.
  - ram_wr_en is never 1 while ram_en is 0.
- ram_addr and ram_wr_data are always driven from the latches, so they are stable from acceptance through RESP.
- Request inputs are ignored outside IDLE; req_addr/req_wdata changes after acceptance have no effect.
- Latency, with W = WAIT_STATES and acceptance at edge T:
  - Write: ram_en in cycle T+1+W, rsp_valid in cycle T+2+W.
  - Read: ram_en in cycle T+1+W, rsp_valid in cycle T+3+W.
- Throughput: one request per W+3 cycles (write) or W+4 cycles (read). Accept is not overlapped with RESP.
- rsp_rdata changes only in CAPTURE; writes leave it unchanged.
- Addresses are used as-is (full range 0..2^ADDR_WIDTH-1), with no wrap arithmetic.
- Reset mid-operation:
  - The transaction is abandoned and no rsp_valid is issued.
  - If rst asserts before the clk edge that ends ACCESS, ram_en is already 0 at that edge, so no RAM write occurs.
- Counter width: enough for 0..255 (8 bits).

Test Plan:
- Reset: hold rst with req_valid=1 toggling -> req_ready=1, rsp_valid=0, ram_en=0, rsp_rdata=0x0000 throughout; no RAM activity.
- W=0: write 0x3000<-0xBEEF, then read 0x3000 ->
  - write: ram_en/ram_wr_en high exactly one cycle at T+1, rsp_valid at T+2;
  - read: ram_en high one cycle with ram_wr_en=0, rsp_valid at T+3 with rsp_rdata=0xBEEF.
- W=3: read of address 0x0042 preloaded with 0x1234 -> ram_en only at T+4, rsp_valid only at T+6, rsp_rdata=0x1234; req_ready=0 from T+1 through T+6.
- Back-to-back: W=0, req_valid held high, req_addr changing every cycle -> requests accepted only in IDLE, one read per 4 cycles; each response carries data for the address latched at its acceptance.
- Boundary addresses: write 0xFFFF<-0xAAAA, write 0x0000<-0x5555, then read both -> 0xAAAA and 0x5555 respectively; a following write leaves rsp_rdata=0x5555.
- Reset mid-operation: W=2 write 0x4000<-0xDEAD; assert rst during WAIT -> no ram_en pulse and no rsp_valid; after release, a read of 0x4000 returns the prior contents, not 0xDEAD.
